// File: rtl/sisc_pkg.sv
// Shared SISC definitions: write-back mux select codes and the SWAP sequencer state encoding.
package sisc_pkg;

    localparam logic [1:0] WB_SEL_A      = 2'd0;
    localparam logic [1:0] WB_SEL_B      = 2'd1;
    localparam logic [1:0] WB_SEL_SWAP_A = 2'd2;
    localparam logic [1:0] WB_SEL_SWAP_B = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2,
        FIN  = 2'd3
    } swap_state_t;

endpackage

// File: rtl/swap_wb_ctrl_if.sv
// Bundle between the control unit / register file and the SWAP write-back sequencer.
interface swap_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] ra_addr;
    logic [ADDR_W-1:0] rb_addr;
    logic [DATA_W-1:0] rf_rd_a;
    logic [DATA_W-1:0] rf_rd_b;
    logic [1:0]        ctrl_sel;
    logic              ctrl_we;
    logic [ADDR_W-1:0] ctrl_wr_addr;
    logic [DATA_W-1:0] swap_a;
    logic [DATA_W-1:0] swap_b;
    logic [1:0]        wb_sel;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic              busy;
    logic              done;

    // The sequencer sees everything from the control unit and register file.
    modport slave (
        input  start, ra_addr, rb_addr, rf_rd_a, rf_rd_b,
        input  ctrl_sel, ctrl_we, ctrl_wr_addr,
        output swap_a, swap_b, wb_sel, rf_we, rf_wr_addr, busy, done
    );

    modport master (
        output start, ra_addr, rb_addr, rf_rd_a, rf_rd_b,
        output ctrl_sel, ctrl_we, ctrl_wr_addr,
        input  swap_a, swap_b, wb_sel, rf_we, rf_wr_addr, busy, done
    );

endinterface

// File: rtl/swap_wb_ctrl.sv
// SWAP write-back sequencer: captures R[ra]/R[rb], then steers two register-file writes
// through the write-back mux; otherwise passes the control unit's write-back straight through.
module swap_wb_ctrl
    import sisc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic      clk,
    input  logic      rst,
    swap_wb_if.slave  bus
);

    swap_state_t       state;
    swap_state_t       state_next;
    logic [DATA_W-1:0] swap_a_q;
    logic [DATA_W-1:0] swap_b_q;
    logic [ADDR_W-1:0] ra_q;
    logic [ADDR_W-1:0] rb_q;
    logic              accept;

    logic [1:0]        wb_sel;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic              busy;
    logic              done;

    // A start outside IDLE is dropped so the operands of the running swap stay intact.
    assign accept = (state == IDLE) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_a_q <= '0;
            swap_b_q <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
        end else if (accept) begin
            swap_a_q <= bus.rf_rd_a;
            swap_b_q <= bus.rf_rd_b;
            ra_q     <= bus.ra_addr;
            rb_q     <= bus.rb_addr;
        end
    end

    always_comb begin
        state_next = state;
        wb_sel     = bus.ctrl_sel;
        rf_we      = bus.ctrl_we;
        rf_wr_addr = bus.ctrl_wr_addr;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = WR_A;
                end
            end
            // R[ra] takes the old R[rb], which the mux presents on its swap_b input.
            WR_A: begin
                state_next = WR_B;
                wb_sel     = WB_SEL_SWAP_B;
                rf_we      = 1'b1;
                rf_wr_addr = ra_q;
                busy       = 1'b1;
            end
            WR_B: begin
                state_next = FIN;
                wb_sel     = WB_SEL_SWAP_A;
                rf_we      = 1'b1;
                rf_wr_addr = rb_q;
                busy       = 1'b1;
            end
            FIN: begin
                state_next = IDLE;
                rf_we      = 1'b0;
                busy       = 1'b1;
                done       = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.swap_a     = swap_a_q;
    assign bus.swap_b     = swap_b_q;
    assign bus.wb_sel     = wb_sel;
    assign bus.rf_we      = rf_we;
    assign bus.rf_wr_addr = rf_wr_addr;
    assign bus.busy       = busy;
    assign bus.done       = done;

endmodule

// File: tb/tb_swap_wb_ctrl.sv
// Directed bench for swap_wb_ctrl with a small register-file/mux model and an expectation queue.
module tb_swap_wb_ctrl;
    import sisc_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    swap_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    swap_wb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Environment: write-back mux feeding a 16-entry register file.
    logic [DATA_W-1:0] wr_data_a;
    logic [DATA_W-1:0] wr_data_b;
    logic [DATA_W-1:0] mux_out;
    logic [DATA_W-1:0] regs [16];

    always_comb begin
        case (bus.wb_sel)
            WB_SEL_A:      mux_out = wr_data_a;
            WB_SEL_B:      mux_out = wr_data_b;
            WB_SEL_SWAP_A: mux_out = bus.swap_a;
            default:       mux_out = bus.swap_b;
        endcase
    end

    always @(posedge clk) begin
        if (bus.rf_we) regs[bus.rf_wr_addr] <= mux_out;
    end

    assign bus.rf_rd_a = regs[bus.ra_addr];
    assign bus.rf_rd_b = regs[bus.rb_addr];

    typedef struct {
        logic [1:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic              fin;
    } exp_t;

    exp_t              sb [$];
    int                vectors     = 0;
    int                miscompares = 0;
    logic [DATA_W-1:0] exp_swap_a  = '0;
    logic [DATA_W-1:0] exp_swap_b  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compares this cycle's outputs against the queued swap step, or the idle pass-through.
    task automatic check_cycle(input string tag);
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".busy"}, 32'(bus.busy), 32'd1);
            check({tag, ".done"}, 32'(bus.done), 32'(e.fin));
            if (e.fin) begin
                check({tag, ".we"},   32'(bus.rf_we),      32'd0);
                check({tag, ".sel"},  32'(bus.wb_sel),     32'(bus.ctrl_sel));
                check({tag, ".addr"}, 32'(bus.rf_wr_addr), 32'(bus.ctrl_wr_addr));
            end else begin
                check({tag, ".we"},   32'(bus.rf_we),      32'd1);
                check({tag, ".sel"},  32'(bus.wb_sel),     32'(e.sel));
                check({tag, ".addr"}, 32'(bus.rf_wr_addr), 32'(e.addr));
            end
        end else begin
            check({tag, ".busy"}, 32'(bus.busy),       32'd0);
            check({tag, ".done"}, 32'(bus.done),       32'd0);
            check({tag, ".we"},   32'(bus.rf_we),      32'(bus.ctrl_we));
            check({tag, ".sel"},  32'(bus.wb_sel),     32'(bus.ctrl_sel));
            check({tag, ".addr"}, 32'(bus.rf_wr_addr), 32'(bus.ctrl_wr_addr));
        end
        check({tag, ".swap_a"}, bus.swap_a, exp_swap_a);
        check({tag, ".swap_b"}, bus.swap_b, exp_swap_b);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] val);
        bus.start        = 1'b0;
        bus.ctrl_sel     = WB_SEL_A;
        bus.ctrl_we      = 1'b1;
        bus.ctrl_wr_addr = addr;
        wr_data_a        = val;
        #1;
        check_cycle("preload");
        next_cycle();
        bus.ctrl_we = 1'b0;
    endtask

    // Start cycle: checks idle behaviour, then queues the three busy cycles.
    task automatic apply_start(input string tag, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        exp_t e;
        bus.start   = 1'b1;
        bus.ra_addr = ra;
        bus.rb_addr = rb;
        #1;
        check_cycle({tag, ".start"});
        exp_swap_a = regs[ra];
        exp_swap_b = regs[rb];
        e = '{sel: WB_SEL_SWAP_B, addr: ra, fin: 1'b0}; sb.push_back(e);
        e = '{sel: WB_SEL_SWAP_A, addr: rb, fin: 1'b0}; sb.push_back(e);
        e = '{sel: WB_SEL_A,      addr: '0, fin: 1'b1}; sb.push_back(e);
        next_cycle();
        bus.start        = 1'b0;
        bus.ctrl_sel     = WB_SEL_B;
        bus.ctrl_we      = 1'b1;
        bus.ctrl_wr_addr = 4'hE;
    endtask

    task automatic swap_tail(input string tag);
        #1; check_cycle({tag, ".wr_a"}); next_cycle();
        #1; check_cycle({tag, ".wr_b"}); next_cycle();
        #1; check_cycle({tag, ".fin"});  next_cycle();
        bus.ctrl_we = 1'b0;
        #1; check_cycle({tag, ".idle"});
    endtask

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.ra_addr      = '0;
        bus.rb_addr      = '0;
        bus.ctrl_sel     = WB_SEL_B;
        bus.ctrl_we      = 1'b1;
        bus.ctrl_wr_addr = 4'd9;
        wr_data_a        = '0;
        wr_data_b        = 32'h0BAD_F00D;
        #2;
        check_cycle("reset");
        @(negedge clk);
        rst         = 1'b0;
        bus.ctrl_we = 1'b0;
        #1;
        check_cycle("post_reset");
        next_cycle();

        write_reg(4'd3, 32'hDEADBEEF);
        write_reg(4'd7, 32'h00000005);
        write_reg(4'd4, 32'h12345678);
        write_reg(4'd1, 32'hA1A1A1A1);
        write_reg(4'd2, 32'hB2B2B2B2);

        // Basic swap
        apply_start("t2", 4'd3, 4'd7);
        swap_tail("t2");
        check("t2.r3", regs[3], 32'h00000005);
        check("t2.r7", regs[7], 32'hDEADBEEF);
        next_cycle();

        // Idle pass-through write
        bus.ctrl_sel     = WB_SEL_B;
        bus.ctrl_we      = 1'b1;
        bus.ctrl_wr_addr = 4'd9;
        wr_data_b        = 32'h99990009;
        #1;
        check_cycle("t3.pass");
        next_cycle();
        bus.ctrl_we = 1'b0;
        check("t3.r9", regs[9], 32'h99990009);

        // ra == rb
        apply_start("t4", 4'd4, 4'd4);
        swap_tail("t4");
        check("t4.r4", regs[4], 32'h12345678);
        next_cycle();

        // start re-pulsed during WR_A is ignored
        apply_start("t5", 4'd3, 4'd7);
        bus.start   = 1'b1;
        bus.ra_addr = 4'd1;
        bus.rb_addr = 4'd2;
        #1; check_cycle("t5.wr_a"); next_cycle();
        bus.start = 1'b0;
        #1; check_cycle("t5.wr_b"); next_cycle();
        #1; check_cycle("t5.fin");  next_cycle();
        bus.ctrl_we = 1'b0;
        #1; check_cycle("t5.idle");
        check("t5.r3", regs[3], 32'hDEADBEEF);
        check("t5.r7", regs[7], 32'h00000005);
        check("t5.r1", regs[1], 32'hA1A1A1A1);
        next_cycle();

        // start together with a pass-through write: capture sees the pre-write value
        bus.ctrl_sel     = WB_SEL_A;
        bus.ctrl_we      = 1'b1;
        bus.ctrl_wr_addr = 4'd1;
        wr_data_a        = 32'h00000055;
        apply_start("t7", 4'd1, 4'd2);
        swap_tail("t7");
        check("t7.r1", regs[1], 32'hB2B2B2B2);
        check("t7.r2", regs[2], 32'hA1A1A1A1);
        next_cycle();

        // Reset during WR_B leaves a partial swap
        apply_start("t6", 4'd3, 4'd7);
        #1; check_cycle("t6.wr_a"); next_cycle();
        #1; check_cycle("t6.wr_b");
        rst         = 1'b1;
        bus.ctrl_we = 1'b0;
        #1;
        sb.delete();
        exp_swap_a = '0;
        exp_swap_b = '0;
        check_cycle("t6.rst");
        next_cycle();
        check("t6.r3", regs[3], 32'h00000005);
        check("t6.r7", regs[7], 32'h00000005);
        rst = 1'b0;
        #1;
        check_cycle("t6.idle");
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
